// File: rtl/exec_pkg.sv
// Shared definitions for the instruction execution unit: widths, opcodes, FSM states.
package exec_pkg;

    localparam int unsigned REG_W = 16;
    localparam int unsigned REG_N = 16;
    localparam int unsigned IMM_W = 7;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned IDX_W = 4;

    localparam logic [OP_W-1:0] OP_LOAD = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADDI = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OP_W-1:0] OP_SUBI = 3'b100;
    localparam logic [OP_W-1:0] OP_MUL  = 3'b101;
    localparam logic [OP_W-1:0] OP_CLR  = 3'b110;
    localparam logic [OP_W-1:0] OP_DPL  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_CLEAR,
        S_PRESENT
    } state_t;

    // Sign-magnitude immediate to two's complement; -0 maps to 0.
    function automatic logic [REG_W-1:0] sm_to_tc(input logic [IMM_W-1:0] imm);
        logic [REG_W-1:0] mag;
        mag = REG_W'(imm[IMM_W-2:0]);
        return imm[IMM_W-1] ? (~mag + REG_W'(1)) : mag;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes and debounces an active-low pushbutton; one-cycle pulse per accepted press.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Counter runs only while the synchronized input differs from the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            level       <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= btn_n;
            sync2       <= sync1;
            press_pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level       <= sync2;
                cnt         <= '0;
                press_pulse <= level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Executes one switch-encoded instruction per button press on a 16x16 register file
// and hands the result to the display stage over valid/ready.
module instr_exec_unit
    import exec_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_button,
    input  logic [OP_W-1:0]  opcode,
    input  logic [IDX_W-1:0] endreg,
    input  logic [IDX_W-1:0] rs1,
    input  logic [IDX_W-1:0] rs2,
    input  logic [IMM_W-1:0] imm,
    output logic             disp_valid,
    input  logic             disp_ready,
    output logic [OP_W-1:0]  disp_op,
    output logic [IDX_W-1:0] disp_reg,
    output logic [REG_W-1:0] disp_value,
    output logic             disp_ovf
);

    logic press_pulse;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (send_button),
        .press_pulse (press_pulse)
    );

    state_t           state_q, state_d;
    logic [OP_W-1:0]  ins_op;
    logic [IDX_W-1:0] ins_rd, ins_rs1, ins_rs2, clr_idx;
    logic [IMM_W-1:0] ins_imm;
    logic [REG_W-1:0] op_a, op_b;
    logic [REG_W-1:0] rf [REG_N];

    logic             latch_ins;
    logic             rf_we;
    logic [IDX_W-1:0] rf_waddr;
    logic [REG_W-1:0] rf_wdata;

    logic [REG_W-1:0]         simm, opnd_b, sum, diff, alu_res;
    logic [2*REG_W-1:0]       prod;
    logic                     alu_ovf;

    // Datapath: single-cycle ALU including the combinational multiplier.
    always_comb begin
        simm    = sm_to_tc(ins_imm);
        opnd_b  = (ins_op == OP_ADDI || ins_op == OP_SUBI) ? simm : op_b;
        sum     = op_a + opnd_b;
        diff    = op_a - opnd_b;
        prod    = {{REG_W{op_a[REG_W-1]}}, op_a} * {{REG_W{op_b[REG_W-1]}}, op_b};
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ins_op)
            OP_LOAD: alu_res = simm;
            OP_ADD, OP_ADDI: begin
                alu_res = sum;
                alu_ovf = (op_a[REG_W-1] == opnd_b[REG_W-1]) && (sum[REG_W-1] != op_a[REG_W-1]);
            end
            OP_SUB, OP_SUBI: begin
                alu_res = diff;
                alu_ovf = (op_a[REG_W-1] != opnd_b[REG_W-1]) && (diff[REG_W-1] != op_a[REG_W-1]);
            end
            OP_MUL: begin
                alu_res = prod[REG_W-1:0];
                alu_ovf = prod[2*REG_W-1:REG_W-1] != {(REG_W+1){prod[REG_W-1]}};
            end
            OP_DPL:  alu_res = op_a;
            default: alu_res = '0;
        endcase
    end

    // Next-state and control decode.
    always_comb begin
        state_d   = state_q;
        latch_ins = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = ins_rd;
        rf_wdata  = alu_res;
        case (state_q)
            S_IDLE: begin
                if (press_pulse) begin
                    latch_ins = 1'b1;
                    state_d   = (opcode == OP_CLR) ? S_CLEAR : S_FETCH;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                rf_we   = (ins_op != OP_DPL);
                state_d = S_PRESENT;
            end
            S_CLEAR: begin
                rf_we    = 1'b1;
                rf_waddr = clr_idx;
                rf_wdata = '0;
                if (clr_idx == IDX_W'(REG_N - 1)) state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (disp_valid && disp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ins_op     <= '0;
            ins_rd     <= '0;
            ins_rs1    <= '0;
            ins_rs2    <= '0;
            ins_imm    <= '0;
            clr_idx    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            disp_valid <= 1'b0;
            disp_op    <= '0;
            disp_reg   <= '0;
            disp_value <= '0;
            disp_ovf   <= 1'b0;
            for (int i = 0; i < REG_N; i++) rf[i] <= '0;
        end else begin
            state_q    <= state_d;
            disp_valid <= (state_d == S_PRESENT);
            if (latch_ins) begin
                ins_op  <= opcode;
                ins_rd  <= endreg;
                ins_rs1 <= rs1;
                ins_rs2 <= rs2;
                ins_imm <= imm;
                clr_idx <= '0;
            end
            if (state_q == S_FETCH) begin
                op_a <= rf[ins_rs1];
                op_b <= rf[ins_rs2];
            end
            if (state_q == S_CLEAR) clr_idx <= clr_idx + IDX_W'(1);
            if (rf_we) rf[rf_waddr] <= rf_wdata;
            if (state_q == S_EXEC) begin
                disp_op    <= ins_op;
                disp_reg   <= (ins_op == OP_DPL) ? ins_rs1 : ins_rd;
                disp_value <= alu_res;
                disp_ovf   <= alu_ovf;
            end
            if (state_q == S_CLEAR && state_d == S_PRESENT) begin
                disp_op    <= OP_CLR;
                disp_reg   <= '0;
                disp_value <= '0;
                disp_ovf   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Randomized scoreboard bench for instr_exec_unit against an integer reference model.
module tb_instr_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_button;
    logic [2:0]  opcode;
    logic [3:0]  endreg, rs1, rs2;
    logic [6:0]  imm;
    logic        disp_valid, disp_ready;
    logic [2:0]  disp_op;
    logic [3:0]  disp_reg;
    logic [15:0] disp_value;
    logic        disp_ovf;

    instr_exec_unit #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .send_button (send_button),
        .opcode      (opcode),
        .endreg      (endreg),
        .rs1         (rs1),
        .rs2         (rs2),
        .imm         (imm),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_op     (disp_op),
        .disp_reg    (disp_reg),
        .disp_value  (disp_value),
        .disp_ovf    (disp_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  rg;
        logic [15:0] val;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    logic signed [15:0] mrf [16];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int press_cyc = 0;
    int pulse_cnt = 0;
    bit armed = 1'b1;
    bit prev_valid = 1'b0;
    bit acc_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency, handshake and field checks against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            armed = 1'b1;
            prev_valid = 1'b0;
            acc_prev = 1'b0;
        end else begin
            if (dut.u_debouncer.press_pulse) begin
                pulse_cnt++;
                if (armed) begin
                    press_cyc = cyc;
                    armed = 1'b0;
                end
            end
            if (acc_prev) chk("valid_drop", 32'(disp_valid), 32'd0);
            if (disp_valid && !prev_valid) begin
                if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - press_cyc), 32'(sb[0].lat));
            end
            if (disp_valid && disp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("disp_op", 32'(disp_op), 32'(e.op));
                    chk("disp_reg", 32'(disp_reg), 32'(e.rg));
                    chk("disp_value", 32'(disp_value), 32'(e.val));
                    chk("disp_ovf", 32'(disp_ovf), 32'(e.ovf));
                end
                armed = 1'b1;
            end
            acc_prev = disp_valid && disp_ready;
            prev_valid = disp_valid;
        end
    end

    function automatic exp_t model(input logic [2:0] op, input logic [3:0] rd,
                                   input logic [3:0] a_i, input logic [3:0] b_i,
                                   input logic [6:0] im);
        exp_t e;
        int s, a, b, full;
        s = im[6] ? -int'(im[5:0]) : int'(im[5:0]);
        a = int'(mrf[a_i]);
        b = int'(mrf[b_i]);
        e.op = op; e.rg = rd; e.ovf = 1'b0; e.lat = 3;
        full = 0;
        case (op)
            3'd0: full = s;
            3'd1: full = a + b;
            3'd2: full = a + s;
            3'd3: full = a - b;
            3'd4: full = a - s;
            3'd5: full = a * b;
            3'd7: begin full = a; e.rg = a_i; end
            default: begin full = 0; e.rg = 4'd0; e.lat = 17; end
        endcase
        e.val = 16'(full);
        if (op != 3'd0 && op != 3'd6 && op != 3'd7)
            e.ovf = (full > 32767) || (full < -32768);
        if (op == 3'd6) for (int i = 0; i < 16; i++) mrf[i] = '0;
        else if (op != 3'd7) mrf[rd] = e.val;
        return e;
    endfunction

    task automatic press(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] a_i,
                         input logic [3:0] b_i, input logic [6:0] im, input bit expect_it);
        opcode = op; endreg = rd; rs1 = a_i; rs2 = b_i; imm = im;
        if (expect_it) sb.push_back(model(op, rd, a_i, b_i, im));
        send_button = 1'b0;
        repeat (12) @(posedge clk);
        #1 send_button = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (i == 5) disp_ready = 1'b1;
            if (sb.size() == 0 && !disp_valid) return;
        end
        chk("idle_timeout", 32'd1, 32'd0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  s_op;
        logic [3:0]  s_rg;
        logic [15:0] s_val;
        logic        s_ovf;
        bit          stable;
        bit          seen;
        int          pc;

        rst = 1'b1; send_button = 1'b1; disp_ready = 1'b1;
        opcode = '0; endreg = '0; rs1 = '0; rs2 = '0; imm = '0;
        for (int i = 0; i < 16; i++) mrf[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(disp_valid), 32'd0);
        chk("rst_op", 32'(disp_op), 32'd0);
        chk("rst_reg", 32'(disp_reg), 32'd0);
        chk("rst_value", 32'(disp_value), 32'd0);
        chk("rst_ovf", 32'(disp_ovf), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        press(3'd0, 4'd3, 4'd0, 4'd0, 7'b0000101, 1'b1); wait_idle();
        press(3'd0, 4'd4, 4'd0, 4'd0, 7'b1000011, 1'b1); wait_idle();
        press(3'd1, 4'd5, 4'd3, 4'd4, 7'b0000000, 1'b1); wait_idle();
        press(3'd4, 4'd6, 4'd5, 4'd0, 7'b0000010, 1'b1); wait_idle();
        press(3'd0, 4'd1, 4'd0, 4'd0, 7'b0111111, 1'b1); wait_idle();
        press(3'd5, 4'd2, 4'd1, 4'd1, 7'b0000000, 1'b1); wait_idle();
        press(3'd5, 4'd3, 4'd2, 4'd2, 7'b0000000, 1'b1); wait_idle();

        // Backpressure: result held stable while a second press is dropped.
        disp_ready = 1'b0;
        press(3'd2, 4'd7, 4'd2, 4'd0, 7'b1000001, 1'b1);
        chk("bp_valid", 32'(disp_valid), 32'd1);
        s_op = disp_op; s_rg = disp_reg; s_val = disp_value; s_ovf = disp_ovf;
        stable = 1'b1;
        fork
            press(3'd0, 4'd8, 4'd0, 4'd0, 7'b0001111, 1'b0);
            for (int i = 0; i < 26; i++) begin
                @(posedge clk); #1;
                if (!disp_valid || disp_op != s_op || disp_reg != s_rg ||
                    disp_value != s_val || disp_ovf != s_ovf) stable = 1'b0;
            end
        join
        chk("bp_stable", 32'(stable), 32'd1);
        disp_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("bp_drained", 32'(sb.size()), 32'd0);

        press(3'd6, 4'd9, 4'd0, 4'd0, 7'b0000000, 1'b1); wait_idle();
        press(3'd7, 4'd0, 4'd2, 4'd0, 7'b0000000, 1'b1); wait_idle();

        press(3'd0, 4'd3, 4'd0, 4'd0, 7'b0001001, 1'b1); wait_idle();
        pc = pulse_cnt;
        for (int g = 0; g < 3; g++) begin
            send_button = 1'b0;
            repeat (3) @(posedge clk);
            #1 send_button = 1'b1;
            repeat (6) @(posedge clk);
            #1;
        end
        chk("glitch_no_pulse", 32'(pulse_cnt - pc), 32'd0);

        // Reset while the instruction is in FETCH.
        opcode = 3'd1; endreg = 4'd3; rs1 = 4'd3; rs2 = 4'd3; imm = '0;
        send_button = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (dut.u_debouncer.press_pulse) seen = 1'b1;
        end
        chk("rst_test_pulse", 32'(seen), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; send_button = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mrf[i] = '0;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (disp_valid) stable = 1'b0;
        end
        chk("rst_discard", 32'(stable), 32'd1);
        press(3'd7, 4'd0, 4'd3, 4'd0, 7'b0000000, 1'b1); wait_idle();

        for (int n = 0; n < 40; n++) begin
            disp_ready = ($urandom_range(0, 3) != 0);
            press(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  7'($urandom_range(0, 127)), 1'b1);
            wait_idle();
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
